// File: rtl/ahb_mtimer_pkg.sv
// Shared definitions for the machine timer: register offsets, AHB transfer
// encodings and the bus-response state type.
package p_hardisc;

  localparam logic [4:0] MTIMER_MTIME_LO = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI = 5'h04;
  localparam logic [4:0] MTIMER_CMP_LO   = 5'h08;
  localparam logic [4:0] MTIMER_CMP_HI   = 5'h0C;
  localparam logic [4:0] MTIMER_CTRL     = 5'h10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} mtimer_state_t;

endpackage

// File: rtl/ahb_mtimer_if.sv
// AHB-Lite slave-side bundle for the machine timer; signal names follow the
// slave's point of view.
interface ahb_mtimer_if;
  logic        s_hsel_i;
  logic [4:0]  s_haddr_i;
  logic [1:0]  s_htrans_i;
  logic        s_hwrite_i;
  logic [2:0]  s_hsize_i;
  logic [31:0] s_hwdata_i;
  logic        s_hready_i;
  logic [31:0] s_hrdata_o;
  logic        s_hreadyout_o;
  logic        s_hresp_o;
  logic [6:0]  s_hrchecksum_o;

  modport slave (
    input  s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i, s_hwdata_i, s_hready_i,
    output s_hrdata_o, s_hreadyout_o, s_hresp_o, s_hrchecksum_o
  );

  modport master (
    output s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i, s_hwdata_i, s_hready_i,
    input  s_hrdata_o, s_hreadyout_o, s_hresp_o, s_hrchecksum_o
  );
endinterface

// File: rtl/ahb_mtimer_secded_enc_32.sv
// SEC-DED (39,32) encoder: check[5:0] are Hamming parities for codeword
// positions 1,2,4,..,32 (data fills the other positions 3..38 in order),
// check[6] is the overall parity of data and Hamming bits.
module secded_enc_32 (
  input  logic [31:0] data_i,
  output logic [6:0]  check_o
);

  function automatic logic [5:0] dataPos(int unsigned i);
    if (i == 0)       return 6'd3;
    else if (i < 4)   return 6'(i + 4);
    else if (i < 11)  return 6'(i + 5);
    else if (i < 26)  return 6'(i + 6);
    else              return 6'(i + 7);
  endfunction

  logic [5:0] ham;

  always_comb begin
    ham = '0;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) ham = ham ^ dataPos(i);
    end
  end

  assign check_o = {^{data_i, ham}, ham};

endmodule

// File: rtl/ahb_mtimer.sv
// RISC-V machine timer on AHB-Lite: 64-bit mtime/mtimecmp, CTRL with enable
// and prescaler, registered mtip. Define MTIMER_HRCHECKSUM_EN for read ECC.
module ahb_mtimer
  import p_hardisc::*;
#(
  parameter int unsigned PRESC_W      = 8,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          s_clk_i,
  input  logic          s_rst_i,
  ahb_mtimer_if.slave   bus,
  output logic          s_int_mtip_o,
  output logic [63:0]   s_mtime_o
);

  mtimer_state_t state_q;
  logic               hreadyout_q, hresp_q, mtip_q;
  logic               dphase_q, dphase_d;
  logic               write_q, write_d;
  logic [4:0]         addr_q, addr_d;
  logic [63:0]        mtime_q, mtime_d, cmp_q, cmp_d;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d, cnt_q, cnt_d;
  logic               accept, legal, tick, wrEn;
  logic [31:0]        ctrlRd, rdata;

  assign accept = bus.s_hsel_i & bus.s_hready_i &
                  ((bus.s_htrans_i == HTRANS_NONSEQ) || (bus.s_htrans_i == HTRANS_SEQ));
  assign legal  = (bus.s_hsize_i == HSIZE_WORD) && (bus.s_haddr_i[1:0] == 2'b00) &&
                  (bus.s_haddr_i <= MTIMER_CTRL);
  assign wrEn   = dphase_q & write_q;
  assign tick   = en_q & (cnt_q == presc_q);

  // Illegal transfers never open a data phase, so they cannot touch registers.
  always_comb begin
    dphase_d = dphase_q;
    write_d  = write_q;
    addr_d   = addr_q;
    if (bus.s_hready_i) begin
      dphase_d = accept & legal;
      write_d  = bus.s_hwrite_i;
      addr_d   = bus.s_haddr_i;
    end
  end

  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (en_q) cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
    if (wrEn) begin
      case (addr_q)
        MTIMER_MTIME_LO: mtime_d = {mtime_q[63:32], bus.s_hwdata_i};
        MTIMER_MTIME_HI: mtime_d = {bus.s_hwdata_i, mtime_q[31:0]};
        MTIMER_CMP_LO:   cmp_d[31:0]  = bus.s_hwdata_i;
        MTIMER_CMP_HI:   cmp_d[63:32] = bus.s_hwdata_i;
        MTIMER_CTRL: begin
          en_d    = bus.s_hwdata_i[0];
          presc_d = bus.s_hwdata_i[8 +: PRESC_W];
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrlRd              = '0;
    ctrlRd[0]           = en_q;
    ctrlRd[8 +: PRESC_W] = presc_q;
    rdata               = '0;
    if (dphase_q && !write_q) begin
      case (addr_q)
        MTIMER_MTIME_LO: rdata = mtime_q[31:0];
        MTIMER_MTIME_HI: rdata = mtime_q[63:32];
        MTIMER_CMP_LO:   rdata = cmp_q[31:0];
        MTIMER_CMP_HI:   rdata = cmp_q[63:32];
        MTIMER_CTRL:     rdata = ctrlRd;
        default:         rdata = '0;
      endcase
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      dphase_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      mtime_q     <= '0;
      cmp_q       <= MTIMECMP_RST;
      en_q        <= 1'b1;
      presc_q     <= '0;
      cnt_q       <= '0;
      mtip_q      <= 1'b0;
    end else begin
      // Two-cycle error response; a new transfer may start in ERR2.
      case (state_q)
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept && !legal) begin
            state_q     <= ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
      dphase_q <= dphase_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      mtip_q   <= (mtime_q >= cmp_q);
    end
  end

  assign bus.s_hrdata_o    = rdata;
  assign bus.s_hreadyout_o = hreadyout_q;
  assign bus.s_hresp_o     = hresp_q;
  assign s_int_mtip_o      = mtip_q;
  assign s_mtime_o         = mtime_q;

`ifdef MTIMER_HRCHECKSUM_EN
  secded_enc_32 u_secded (
    .data_i  (rdata),
    .check_o (bus.s_hrchecksum_o)
  );
`else
  assign bus.s_hrchecksum_o = 7'b0;
`endif

endmodule

// File: doc/ahb_mtimer.md
Name: ahb_mtimer

Overview:
- Memory-mapped RISC-V machine timer on the core's AHB-Lite data bus.
- Holds 64-bit mtime/mtimecmp, a control register and a prescaler.
- Produces the registered timer interrupt that drives the core's s_int_mtip_i input.
- Answers the data bus with zero-wait-state reads/writes and a two-cycle AHB error response on illegal accesses.

Parameters:
- PRESC_W, 8, width of prescaler field in CTRL.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- s_clk_i  in  1  clock
- s_rst_i  in  1  synchronous reset, active-high
- s_hsel_i  in  1  slave select
- s_haddr_i  in  5  byte address offset within the timer window
- s_htrans_i  in  2  AHB transfer type
- s_hwrite_i  in  1  write indicator
- s_hsize_i  in  3  transfer size
- s_hwdata_i  in  32  write data, valid in data phase
- s_hready_i  in  1  bus-level HREADY (address-phase qualifier)
- s_hrdata_o  out  32  read data
- s_hreadyout_o  out  1  slave ready
- s_hresp_o  out  1  error response
- s_hrchecksum_o  out  7  read-data checksum (see Optional Feature)
- s_int_mtip_o  out  1  timer interrupt pending, to core s_int_mtip_i
- s_mtime_o  out  64  current mtime, for debug/trace

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bits[8+PRESC_W-1:8] PRESC, others read 0 / ignore writes.
- Reset values:
  - mtime = 0
  - mtimecmp = MTIMECMP_RST
  - EN = 1, PRESC = 0
  - s_int_mtip_o = 0, s_hreadyout_o = 1, s_hresp_o = 0, s_hrdata_o = 0
  - prescale counter = 0
- Address phase:
  - Accepted when s_hsel_i & s_hready_i & s_htrans_i[1].
  - Registers addr, write, and valid flag.
  - Registers the legality check: s_hsize_i==3'b010, s_haddr_i[1:0]==0, offset <= 0x10.
- Legal data phase:
  - s_hreadyout_o = 1, s_hresp_o = 0, single cycle.
  - Read: s_hrdata_o is combinational from the register selected by the captured address, with live value.
  - Write: s_hwdata_o is latched into the target register at the end of the data-phase cycle.
- Illegal access uses FSM IDLE -> ERR1 -> ERR2 -> IDLE:
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - No register is modified.
  - A new address phase accepted in ERR2 proceeds normally.
- IDLE/BUSY transfers and hsel=0: OKAY response, no effect.
- Prescaler:
  - When EN=1, the prescale counter increments each cycle.
  - When count==PRESC, count clears and mtime increments by 1 (64-bit, wraps 2^64-1 -> 0).
  - PRESC=0: mtime increments every cycle.
  - EN=0: counter and mtime hold.
- Simultaneous events:
  - A software write to MTIME_LO or MTIME_HI in the same cycle as a tick wins over the increment; the other half keeps its pre-increment value.
  - A CTRL write clears the prescale counter.
- s_int_mtip_o is registered: next value = (mtime >= mtimecmp), evaluated on post-update register values, so it lags by 1 cycle. It is level, not latched; writing mtimecmp above mtime deasserts it the cycle after.
- Reset mid-transfer: FSM returns to IDLE, the pending data phase is discarded, and outputs take reset values.
- Reading the 64-bit halves is not atomic; software uses the HI/LO/HI sequence.

Optional Feature:
- Macro: MTIMER_HRCHECKSUM_EN.
- Defined: s_hrchecksum_o = 7-bit SEC-DED (39,32) check bits of s_hrdata_o, combinational in the data phase. This is the same code the core's LSU checks on s_d_hrchecksum_i.
- Undefined: s_hrchecksum_o tied to 7'b0 and the encoder is not instantiated.

Decomposition:
- Shared package p_hardisc gets:
  - offset constants MTIMER_MTIME_LO/HI, MTIMER_CMP_LO/HI, MTIMER_CTRL
  - htrans encodings
  - the mtimer_state_t enum (IDLE, ERR1, ERR2)
- One sub-module: secded_enc_32, a combinational encoder, instantiated only under MTIMER_HRCHECKSUM_EN.

Test Plan:
- Release reset, PRESC=0, idle 10 cycles -> MTIME_LO read returns 10 (+/-1 per bus phase), s_int_mtip_o=0, MTIMECMP_HI=0xFFFFFFFF.
- Write CTRL=0x0000_0301 (PRESC=3), idle 40 cycles -> mtime advances exactly 10; CTRL read returns 0x0000_0301.
- Write mtime=0x0000_0000_FFFF_FFFE, PRESC=0 -> after 2 ticks MTIME_HI=1 and MTIME_LO=0; carry is correct.
- Write MTIMECMP_LO=20, MTIMECMP_HI=0 with mtime=0 -> s_int_mtip_o rises one cycle after mtime reaches 20. Then write MTIMECMP_LO=1000 -> it falls the following cycle.
- Byte write (hsize=000) to 0x08, and word read at 0x14 -> each gives ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); mtimecmp unchanged.
- With MTIMER_HRCHECKSUM_EN, read of 0x12345678 -> s_hrchecksum_o matches the reference encoder; assert s_rst_i in ERR1 -> next cycle hreadyout=1, hresp=0.
